seven_seg_scan_mux: RTL and testbench
=====================================

Name: seven_seg_scan_mux

Overview:
Parametrised time-multiplexed driver for a common-anode/cathode 7-segment array. It is the next-generation successor to the fixed 4-digit display switcher in the stopwatch. Digit count, segment width, dwell time and output polarity are parameters. It adds anti-ghosting dead time, PWM brightness, per-digit blanking, slot-aligned input snapshots and a frame marker. It sits between the BCD-to-segment decoders and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
SEG_WIDTH, 7, segment lines per digit (8 when DP used)
DWELL_CYCLES, 10000, clock cycles per digit slot (> BLANK_CYCLES + 2**BRIGHT_WIDTH)
BLANK_CYCLES, 100, dead-time cycles at slot start with all digits off (0 allowed)
BRIGHT_WIDTH, 4, brightness control width
ANODE_ACTIVE_LOW, 1, 1 = digit select active-low
SEG_ACTIVE_LOW, 0, 1 = invert Segments before driving; "off" = all lines at inactive level

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Enable  in  1  scan enable; low = display dark
Segments  in  NUM_DIGITS*SEG_WIDTH  digit i at [i*SEG_WIDTH +: SEG_WIDTH], active-high pattern
DigitBlank  in  NUM_DIGITS  1 = digit i forced dark during its slot
Brightness  in  BRIGHT_WIDTH  duty = (Brightness+1)/2**BRIGHT_WIDTH of the SHOW phase
DisplayOut  out  NUM_DIGITS  digit selects, polarity per ANODE_ACTIVE_LOW
SegmentsOut  out  SEG_WIDTH  segment drive, polarity per SEG_ACTIVE_LOW
DigitIndex  out  clog2(NUM_DIGITS)  digit currently owning the slot
FrameStart  out  1  one-cycle pulse at start of digit-0 slot

Behaviour:
- Reset is synchronous and active-high; one clock domain, Clock.
- Reset values:
  - DisplayOut all inactive; SegmentsOut all inactive.
  - DigitIndex 0; FrameStart 0.
  - SlotCnt 0; PwmCnt 0; state IDLE.
- States: IDLE, BLANK, SHOW.
  - IDLE: outputs dark, counters held at 0, DigitIndex 0.
  - Enable=1 in IDLE -> next cycle enters BLANK, or SHOW when BLANK_CYCLES=0, with SlotCnt=0 and DigitIndex=0. FrameStart pulses that cycle.
- SlotCnt runs 0..DWELL_CYCLES-1.
  - BLANK covers SlotCnt < BLANK_CYCLES: all selects inactive, segments inactive.
  - SHOW covers the rest of the slot.
- SHOW phase:
  - PwmCnt (BRIGHT_WIDTH bits) starts at 0 on SHOW entry and wraps freely.
  - Digit lit when PwmCnt <= Brightness and DigitBlank[DigitIndex]=0; otherwise dark (selects and segments inactive).
  - Brightness all-ones = 100% duty.
- Slot end (SlotCnt = DWELL_CYCLES-1):
  - DigitIndex increments, wrapping NUM_DIGITS-1 -> 0; SlotCnt returns to 0.
  - The new digit's Segments slice and DigitBlank bit are snapshotted. Changes mid-slot have no effect until the next slot of that digit.
  - Brightness is sampled continuously.
- FrameStart=1 exactly on the first cycle of each digit-0 slot.
- Outputs are registered: pins reflect state/counters one cycle later. Never more than one select active. At least BLANK_CYCLES all-dark cycles between consecutive lit digits.
- Enable falling:
  - Next cycle state=IDLE and outputs dark, even mid-slot.
  - Re-enable restarts at digit 0.
- Reset mid-scan: same as the reset values on the next edge.
- Reset has priority over Enable.
- Simultaneous slot end and Enable fall: IDLE wins.

Decomposition:
- Package seven_seg_pkg:
  - state enum (IDLE/BLANK/SHOW);
  - function clog2;
  - constant ALL_OFF helper deriving inactive levels from polarity parameters.
- One sub-module, scan_slot_timer:
  - SlotCnt/PwmCnt counters and phase decode;
  - outputs slot_end, in_show, pwm_on.
- Top level holds index, snapshot registers and output polarity/register stage.

Test Plan:
Common parameters: NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2, BRIGHT_WIDTH=2, ANODE_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0, Brightness=3.
1. Reset held 3 cycles, Enable=1 -> DisplayOut=1111, SegmentsOut=0 during reset. After release, cycles 1-2 dark, then 1110 with Segments slice 0 for 6 cycles. FrameStart on first cycle only.
2. Full frame -> selects 1110,1101,1011,0111 each 6 cycles separated by 2 dark cycles. DigitIndex 0..3 wraps to 0. FrameStart period 32 cycles.
3. Brightness=0 -> in each SHOW phase the digit is lit only when PwmCnt=0: 1 lit, 3 dark, repeating. Brightness=1 -> 2 of 4 lit.
4. DigitBlank=0100 -> slot 2 completely dark (1111); other digits unaffected, timing unchanged.
5. Change Segments slice 1 from 7'h3F to 7'h06 mid-slot-1 -> 7'h3F persists to end of slot; 7'h06 appears on the next frame's slot 1.
6. Enable dropped mid-slot 2, Reset pulsed mid-slot 1 -> dark on next registered cycle. After re-enable or reset release, restart at digit 0 with FrameStart.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constant helpers for the 7-segment scan multiplexer.
// Latency: n/a (types, functions and constants only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Scan phases: IDLE = dark and parked, BLANK = dead time, SHOW = PWM-lit part of a slot.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Bits needed to hold 0..value-1; usable in parameter and port declarations.
  function automatic int clog2(input int value);
    int width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Inactive ("off") level replicated across up to 64 lines; callers cast to their width.
  function automatic logic [63:0] all_off(input int active_low);
    return (active_low != 0) ? {64{1'b1}} : {64{1'b0}};
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot and PWM counters for the digit scan, plus phase decode of the current slot.
// Latency: counters advance one step per clock while run is high; decode is combinational.
// Backpressure: none; run low parks both counters at zero on the next edge.
module scan_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 10000,
  parameter int BLANK_CYCLES = 100,
  parameter int BRIGHT_WIDTH = 4,
  localparam int SLOT_W = clog2(DWELL_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  output logic                    slot_first,
  output logic                    slot_end,
  output logic                    blank_done,
  output logic                    in_show,
  output logic                    pwm_on
);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DWELL_CYCLES - 1);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [BRIGHT_WIDTH-1:0] pwm_cnt;

  assign slot_first = (slot_cnt == '0);
  assign slot_end   = (slot_cnt == SLOT_LAST);
  // Never true when there is no dead time, so the FSM skips BLANK entirely.
  assign blank_done = (int'(slot_cnt) == BLANK_CYCLES - 1);
  assign in_show    = (int'(slot_cnt) >= BLANK_CYCLES);
  // Brightness is read live, so a change shows up within one PWM period.
  assign pwm_on     = (pwm_cnt <= brightness);

  // Slot position: 0..DWELL_CYCLES-1, wrapping at slot end, held at 0 when not scanning.
  always_ff @(posedge clk) begin
    if (rst || !run || slot_end) slot_cnt <= '0;
    else                         slot_cnt <= slot_cnt + SLOT_W'(1);
  end

  // PWM phase: zero through dead time so the first SHOW cycle always sees 0, then free-wraps.
  always_ff @(posedge clk) begin
    if (rst || !run || !in_show || slot_end) pwm_cnt <= '0;
    else                                     pwm_cnt <= pwm_cnt + BRIGHT_WIDTH'(1);
  end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed 7-segment driver: dead time, PWM brightness, per-digit blanking, frame marker.
// Latency: pins are registered and follow the internal scan state by one clock.
// Backpressure: none; Enable low or Reset darkens the pins on the next edge.
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SEG_WIDTH        = 7,
  parameter int DWELL_CYCLES     = 10000,
  parameter int BLANK_CYCLES     = 100,
  parameter int BRIGHT_WIDTH     = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 0,
  localparam int IDX_W = clog2(NUM_DIGITS)
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Enable,
  input  logic [NUM_DIGITS*SEG_WIDTH-1:0] Segments,
  input  logic [NUM_DIGITS-1:0]           DigitBlank,
  input  logic [BRIGHT_WIDTH-1:0]         Brightness,
  output logic [NUM_DIGITS-1:0]           DisplayOut,
  output logic [SEG_WIDTH-1:0]            SegmentsOut,
  output logic [IDX_W-1:0]                DigitIndex,
  output logic                            FrameStart
);

  // Inactive pin levels; polarity helpers cover up to 64 lines per bus.
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = NUM_DIGITS'(all_off(ANODE_ACTIVE_LOW));
  localparam logic [SEG_WIDTH-1:0]  SEG_OFF = SEG_WIDTH'(all_off(SEG_ACTIVE_LOW));
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // With no dead time a slot opens straight into SHOW.
  localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  scan_state_t            state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [SEG_WIDTH-1:0]   snap_seg;
  logic                   snap_blank;
  logic                   run, slot_first, slot_end, blank_done, in_show, pwm_on;
  logic                   lit;
  logic [NUM_DIGITS-1:0]  onehot;
  logic [NUM_DIGITS-1:0]  sel_nxt;
  logic [SEG_WIDTH-1:0]   seg_nxt;
  logic [IDX_W-1:0]       index_nxt;
  logic                   frame_nxt;

  // Counters only run while scanning; an Enable drop zeroes them on the same edge as IDLE entry.
  assign run = (state != IDLE) && Enable;

  scan_slot_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BRIGHT_WIDTH (BRIGHT_WIDTH)
  ) u_timer (
    .clk        (Clock),
    .rst        (Reset),
    .run        (run),
    .brightness (Brightness),
    .slot_first (slot_first),
    .slot_end   (slot_end),
    .blank_done (blank_done),
    .in_show    (in_show),
    .pwm_on     (pwm_on)
  );

  assign idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

  // Scan phase register; Reset beats Enable.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Phase sequencing; Enable low wins over any slot boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable) state_nxt = SLOT_START;
      BLANK:   if (!Enable) state_nxt = IDLE;
               else if (blank_done) state_nxt = SHOW;
      SHOW:    if (!Enable) state_nxt = IDLE;
               else if (slot_end) state_nxt = SLOT_START;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot owner and per-slot snapshot; inputs are latched only when a digit takes its slot.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx        <= '0;
      snap_seg   <= '0;
      snap_blank <= 1'b0;
    end else if (state == IDLE) begin
      idx <= '0;
      if (Enable) begin
        snap_seg   <= Segments[SEG_WIDTH-1:0];
        snap_blank <= DigitBlank[0];
      end
    end else if (!Enable) begin
      idx <= '0;
    end else if (slot_end) begin
      idx        <= idx_next;
      snap_seg   <= Segments[int'(idx_next)*SEG_WIDTH +: SEG_WIDTH];
      snap_blank <= DigitBlank[idx_next];
    end
  end

  // Pin values for the next cycle: one select at most, everything off unless lit.
  always_comb begin
    onehot    = '0;
    sel_nxt   = SEL_OFF;
    seg_nxt   = SEG_OFF;
    lit       = (state == SHOW) && in_show && pwm_on && !snap_blank;
    index_nxt = Enable ? idx : '0;
    frame_nxt = Enable && (state != IDLE) && slot_first && (idx == '0);
    if (Enable && lit) begin
      onehot[idx] = 1'b1;
      sel_nxt     = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
      seg_nxt     = (SEG_ACTIVE_LOW != 0) ? ~snap_seg : snap_seg;
    end
  end

  // Output register stage driving the board pins.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      DisplayOut  <= SEL_OFF;
      SegmentsOut <= SEG_OFF;
      DigitIndex  <= '0;
      FrameStart  <= 1'b0;
    end else begin
      DisplayOut  <= sel_nxt;
      SegmentsOut <= seg_nxt;
      DigitIndex  <= index_nxt;
      FrameStart  <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Self-checking bench for seven_seg_scan_mux with a 4-digit, 8-cycle-slot configuration.
// Latency: expected pins are queued one edge ahead and popped by a negedge monitor.
// Backpressure: n/a.
module tb_seven_seg_scan_mux;

  localparam int ND = 4;
  localparam int SW = 7;
  localparam int DW = 8;
  localparam int BC = 2;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              Reset;
  logic              Enable;
  logic [ND*SW-1:0]  Segments;
  logic [ND-1:0]     DigitBlank;
  logic [BW-1:0]     Brightness;
  logic [ND-1:0]     DisplayOut;
  logic [SW-1:0]     SegmentsOut;
  logic [1:0]        DigitIndex;
  logic              FrameStart;

  always #5 clk = ~clk;

  seven_seg_scan_mux #(
    .NUM_DIGITS       (ND),
    .SEG_WIDTH        (SW),
    .DWELL_CYCLES     (DW),
    .BLANK_CYCLES     (BC),
    .BRIGHT_WIDTH     (BW),
    .ANODE_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW   (0)
  ) dut (
    .Clock       (clk),
    .Reset       (Reset),
    .Enable      (Enable),
    .Segments    (Segments),
    .DigitBlank  (DigitBlank),
    .Brightness  (Brightness),
    .DisplayOut  (DisplayOut),
    .SegmentsOut (SegmentsOut),
    .DigitIndex  (DigitIndex),
    .FrameStart  (FrameStart)
  );

  typedef struct packed {
    logic [ND-1:0] sel;
    logic [SW-1:0] seg;
    logic [1:0]    idx;
    logic          fs;
  } pins_t;

  pins_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference timeline: m_t counts cycles since the scan started; slot/digit/PWM follow from it.
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [SW-1:0] m_seg[ND];
  bit          m_blank[ND];

  int lit_cnt = 0;
  int ncyc    = 0;
  int last_fs = -1;
  int fs_gap  = 0;

  function automatic pins_t model_pins();
    pins_t p;
    int    slot, dig, pwm;
    bit    lit;
    p.sel = 4'hF;
    p.seg = '0;
    p.idx = 2'd0;
    p.fs  = 1'b0;
    if (!Reset && Enable && m_active) begin
      slot  = m_t % DW;
      dig   = (m_t / DW) % ND;
      pwm   = (slot - BC) % 4;
      lit   = (slot >= BC) && (pwm <= int'(Brightness)) && !m_blank[dig];
      p.idx = 2'(dig);
      p.fs  = ((m_t % (DW * ND)) == 0);
      if (lit) begin
        p.sel = ~(4'b0001 << dig);
        p.seg = m_seg[dig];
      end
    end
    return p;
  endfunction

  task automatic capture(input int d);
    m_seg[d]   = Segments[d*SW +: SW];
    m_blank[d] = DigitBlank[d];
  endtask

  // Queue the pins expected after the next edge, then advance the timeline across that edge.
  task automatic step(input int n);
    repeat (n) begin
      exp_q.push_back(model_pins());
      @(posedge clk);
      #1;
      if (Reset || !Enable) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
        capture(0);
      end else begin
        m_t++;
        if ((m_t % DW) == 0) capture((m_t / DW) % ND);
      end
    end
  endtask

  task automatic step_until(input int d, input int s);
    int n = 0;
    while (!(m_active && ((m_t / DW) % ND) == d && (m_t % DW) == s) && n < 100) begin
      step(1);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL reach_slot got=timeout want=digit %0d slot %0d", d, s);
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: compare pins against the queued expectation on every falling edge.
  always @(negedge clk) begin : monitor
    pins_t e;
    pins_t a;
    ncyc++;
    a = {DisplayOut, SegmentsOut, DigitIndex, FrameStart};
    if (DisplayOut != 4'hF) lit_cnt++;
    if (FrameStart === 1'b1) begin
      if (last_fs >= 0) fs_gap = ncyc - last_fs;
      last_fs = ncyc;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL pins cyc=%0d got sel=%b seg=%h idx=%0d fs=%b want sel=%b seg=%h idx=%0d fs=%b",
                 ncyc, a.sel, a.seg, a.idx, a.fs, e.sel, e.seg, e.idx, e.fs);
      end
    end
  end

  initial begin
    Reset      = 1'b1;
    Enable     = 1'b1;
    Segments   = {7'h66, 7'h4F, 7'h3F, 7'h5B};
    DigitBlank = '0;
    Brightness = 2'd3;

    // Reset held three cycles with Enable already high, then the first frame and a bit.
    step(3);
    Reset = 1'b0;
    step(40);

    // Brightness 0: 2 lit cycles per slot (PWM 0 twice in 6 SHOW cycles) -> 8 per frame.
    Brightness = 2'd0;
    step(1);
    lit_cnt = 0;
    step(32);
    check_count("lit_bright0", lit_cnt, 8);
    check_count("frame_period", fs_gap, 32);

    // Brightness 1: 4 lit per slot -> 16 per frame.
    Brightness = 2'd1;
    step(1);
    lit_cnt = 0;
    step(32);
    check_count("lit_bright1", lit_cnt, 16);

    // Full brightness: whole 6-cycle SHOW phase lit -> 24 per frame.
    Brightness = 2'd3;
    step(1);
    lit_cnt = 0;
    step(32);
    check_count("lit_bright3", lit_cnt, 24);

    // Digit 2 blanked: its 6 lit cycles vanish -> 18 per frame.
    DigitBlank = 4'b0100;
    step(32);
    lit_cnt = 0;
    step(32);
    check_count("lit_blank2", lit_cnt, 18);
    DigitBlank = '0;
    step(32);

    // Digit 1 pattern changed mid-slot: old pattern to slot end, new one next frame.
    step_until(1, 4);
    Segments[13:7] = 7'h06;
    step(40);

    // Enable dropped mid-slot 2, then restored: dark at once, restart at digit 0.
    step_until(2, 5);
    Enable = 1'b0;
    step(3);
    Enable = 1'b1;
    step(40);

    // Reset pulsed mid-slot 1: dark next edge, restart at digit 0 with FrameStart.
    step_until(1, 4);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    step(40);

    @(negedge clk);
    #1;
    check_count("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
